// File: rtl/nios_system_button_pio.sv
// nios_system_button_pio: Avalon-MM input PIO with per-bit sync + debounce,
//   sticky edge capture (W1C) and a maskable level irq.
// Latency: reads 1 cycle; in_port to deb is DEBOUNCE_CYCLES+2 edges;
//   deb change to edge_cap/irq is 1 more edge.
// Backpressure: none; the slave always accepts, with zero wait states.
// Ports: clk, reset_n (sync, active-low), address/chipselect/write_n/writedata
//   (Avalon slave), in_port (raw pins), readdata (registered), irq (level).
module nios_system_button_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_d;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] cap_clr;
  logic             wr;
  logic [31:0]      rd_nxt;

  // Two-flop synchroniser for the asynchronous pins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: a new level is accepted only after it has differed
  // from the stable level for DEBOUNCE_CYCLES consecutive edges.
  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    logic [CW-1:0] cnt;
    logic          deb_bit;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        cnt     <= '0;
        deb_bit <= 1'b0;
      end else if (sync2[i] == deb_bit) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb_bit <= sync2[i];
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

    assign deb[i] = deb_bit;
  end

  // Edge event on the debounced value, selected at elaboration.
  if (EDGE_MODE == 0) begin : g_rise
    assign ev = deb & ~deb_d;
  end else if (EDGE_MODE == 1) begin : g_fall
    assign ev = ~deb & deb_d;
  end else begin : g_both
    assign ev = deb ^ deb_d;
  end

  assign wr      = chipselect & ~write_n;
  assign wdat    = writedata[WIDTH-1:0];
  assign cap_clr = (wr && address == 2'd3) ? wdat : '0;

  // Set is OR-ed in after the clear so a coinciding event keeps its bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      deb_d    <= '0;
      edge_cap <= '0;
      irq_mask <= '0;
    end else begin
      deb_d    <= deb;
      edge_cap <= (edge_cap & ~cap_clr) | ev;
      if (wr && address == 2'd2) begin
        irq_mask <= wdat;
      end
    end
  end

  always_comb begin
    rd_nxt = '0;
    case (address)
      2'd0:    rd_nxt[WIDTH-1:0] = deb;
      2'd2:    rd_nxt[WIDTH-1:0] = irq_mask;
      2'd3:    rd_nxt[WIDTH-1:0] = edge_cap;
      default: rd_nxt = '0;
    endcase
  end

  // Read data tracks the address every cycle; chipselect only gates writes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_nxt;
    end
  end

  // Driven only from registers, so no combinational glitches reach the CPU.
  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_nios_system_button_pio.sv
module tb_nios_system_button_pio;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  inp [3];
  logic [31:0] rd [3];
  logic        irq_o [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nios_system_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .EDGE_MODE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(inp[0]),
    .readdata(rd[0]), .irq(irq_o[0]));
  nios_system_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .EDGE_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(inp[1]),
    .readdata(rd[1]), .irq(irq_o[1]));
  nios_system_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .EDGE_MODE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(inp[2]),
    .readdata(rd[2]), .irq(irq_o[2]));

  // Reference model: debounced level flips when the last D synchronised
  // samples all disagree with it; registers follow the register map.
  logic [3:0]  m_s1 [3];
  logic [3:0]  m_s2 [3];
  logic [3:0]  m_win [3][D];
  logic [3:0]  m_deb [3];
  logic [3:0]  m_debd [3];
  logic [3:0]  m_cap [3];
  logic [3:0]  m_mask [3];
  logic [31:0] m_rd [3];

  task automatic model_update();
    logic [3:0] ev;
    logic [3:0] nd;
    logic [3:0] clr;
    logic       all_diff;
    logic       w;
    for (int m = 0; m < 3; m++) begin
      if (!reset_n) begin
        m_s1[m] = 4'h0; m_s2[m] = 4'h0; m_deb[m] = 4'h0; m_debd[m] = 4'h0;
        m_cap[m] = 4'h0; m_mask[m] = 4'h0; m_rd[m] = 32'h0;
        for (int j = 0; j < D; j++) m_win[m][j] = 4'h0;
      end else begin
        w = chipselect && !write_n;
        case (address)
          2'd0:    m_rd[m] = {28'h0, m_deb[m]};
          2'd2:    m_rd[m] = {28'h0, m_mask[m]};
          2'd3:    m_rd[m] = {28'h0, m_cap[m]};
          default: m_rd[m] = 32'h0;
        endcase
        case (m)
          0:       ev = m_deb[m] & ~m_debd[m];
          1:       ev = ~m_deb[m] & m_debd[m];
          default: ev = m_deb[m] ^ m_debd[m];
        endcase
        clr = (w && address == 2'd3) ? writedata[3:0] : 4'h0;
        m_cap[m] = (m_cap[m] & ~clr) | ev;
        if (w && address == 2'd2) m_mask[m] = writedata[3:0];
        for (int j = 0; j < D - 1; j++) m_win[m][j] = m_win[m][j+1];
        m_win[m][D-1] = m_s2[m];
        nd = m_deb[m];
        for (int i = 0; i < 4; i++) begin
          all_diff = 1'b1;
          for (int j = 0; j < D; j++)
            if (m_win[m][j][i] == m_deb[m][i]) all_diff = 1'b0;
          if (all_diff) nd[i] = ~m_deb[m][i];
        end
        m_debd[m] = m_deb[m];
        m_deb[m]  = nd;
        m_s2[m]   = m_s1[m];
        m_s1[m]   = inp[m];
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Drive one bus cycle, let one edge pass, return at the following negedge.
  task automatic step(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle(input logic [1:0] a);
    step(1'b0, 1'b1, a, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    step(1'b1, 1'b0, a, wd);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idle(2'd0);
      for (int m = 0; m < 3; m++) begin
        check($sformatf("rst_rd%0d", m), rd[m], 32'h0);
        check($sformatf("rst_irq%0d", m), {31'h0, irq_o[m]}, 32'h0);
      end
    end
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        cs;
    logic        wn;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;
  } vec_t;

  vec_t tbl [14];
  int   hold [3][4];

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 32'h0;
    inp[0] = 4'hF; inp[1] = 4'h0; inp[2] = 4'h0;

    // Reset with all buttons held: deb rises 10 edges after release.
    do_reset();
    for (int k = 1; k <= 11; k++) begin
      idle(2'd0);
      if (k == 10) check("t1_deb_edge10", rd[0], 32'h0);
      if (k == 11) check("t1_deb_edge11", rd[0], 32'hF);
    end
    idle(2'd3);
    check("t1_cap", rd[0], 32'hF);
    check("t1_irq", {31'h0, irq_o[0]}, 32'h0);

    // Register map vectors, starting from deb=F, edge_cap=F, irq_mask=0.
    tbl[0]  = '{1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF, 32'hF, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 2'd3, 32'h0,         32'h0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'hF, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'h0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 2'd2, 32'h0,         32'hF, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 2'd0, 32'h0,         32'hF, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 2'd2, 32'h0,         32'hF, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 2'd2, 32'h0,         32'hF, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 2'd2, 32'h0,         32'hF, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 2'd2, 32'h0,         32'h0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 2'd2, 32'h5,         32'h0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 2'd1, 32'h0,         32'h0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 2'd2, 32'h0,         32'h5, 1'b0};
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].cs, tbl[i].wn, tbl[i].addr, tbl[i].wd);
      check($sformatf("tbl%0d_rd", i), rd[0], tbl[i].rd);
      check($sformatf("tbl%0d_irq", i), {31'h0, irq_o[0]}, {31'h0, tbl[i].irq});
    end

    // Debounce reject: 7 high, 1 low, then high; accepted only after 8 clean.
    inp[0] = 4'h0;
    do_reset();
    for (int k = 0; k < 3; k++) idle(2'd0);
    for (int k = 1; k <= 23; k++) begin
      inp[0] = (k == 8) ? 4'h0 : 4'h1;
      idle(2'd0);
      check($sformatf("t2_deb_k%0d", k), rd[0], (k >= 19) ? 32'h1 : 32'h0);
    end

    // Edge capture and irq.
    wr(2'd3, 32'hF);
    wr(2'd2, 32'h2);
    inp[0] = 4'h3;
    for (int k = 0; k < 13; k++) idle(2'd3);
    check("t3_cap_b1", rd[0], 32'h2);
    check("t3_irq_b1", {31'h0, irq_o[0]}, 32'h1);
    inp[0] = 4'h7;
    for (int k = 0; k < 13; k++) idle(2'd3);
    check("t3_cap_b2", rd[0], 32'h6);
    check("t3_irq_b2", {31'h0, irq_o[0]}, 32'h1);
    wr(2'd3, 32'h2);
    check("t3_irq_clr", {31'h0, irq_o[0]}, 32'h0);
    idle(2'd3);
    check("t3_cap_clr", rd[0], 32'h4);

    // Set/clear collision on bit 0.
    inp[0] = 4'h6;
    for (int k = 0; k < 13; k++) idle(2'd0);
    inp[0] = 4'h7;
    for (int j = 0; j <= 8; j++) idle(2'd0);
    idle(2'd0);
    check("t4_deb_pre", rd[0], 32'h6);
    wr(2'd3, 32'h1);
    check("t4_cap_pre", rd[0], 32'h4);
    idle(2'd3);
    check("t4_cap_post", rd[0], 32'h5);
    idle(2'd0);
    check("t4_deb_post", rd[0], 32'h7);

    // Falling-edge and both-edge modes.
    inp[0] = 4'h0;
    do_reset();
    for (int k = 0; k < 3; k++) idle(2'd3);
    wr(2'd2, 32'h1);
    inp[1] = 4'h8;
    for (int k = 0; k < 13; k++) idle(2'd3);
    check("t6_m1_rise", rd[1], 32'h0);
    inp[1] = 4'h0;
    for (int k = 0; k < 13; k++) idle(2'd3);
    check("t6_m1_fall", rd[1], 32'h8);
    inp[2] = 4'h1;
    for (int k = 0; k < 13; k++) idle(2'd3);
    check("t6_m2_rise", rd[2], 32'h1);
    wr(2'd3, 32'h1);
    idle(2'd3);
    check("t6_m2_clr", rd[2], 32'h0);
    inp[2] = 4'h0;
    for (int k = 0; k < 13; k++) idle(2'd3);
    check("t6_m2_fall", rd[2], 32'h1);
    check("t6_m2_irq", {31'h0, irq_o[2]}, 32'h1);

    // Randomised traffic against the reference model, all three modes.
    for (int m = 0; m < 3; m++)
      for (int i = 0; i < 4; i++) hold[m][i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 3; m++)
        for (int i = 0; i < 4; i++) begin
          if (hold[m][i] == 0) begin
            inp[m][i] = 1'($urandom_range(0, 1));
            hold[m][i] = $urandom_range(1, 14);
          end
          hold[m][i]--;
        end
      reset_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), $urandom);
      for (int m = 0; m < 3; m++) begin
        check($sformatf("rand_rd_m%0d_c%0d", m, c), rd[m], m_rd[m]);
        check($sformatf("rand_irq_m%0d_c%0d", m, c), {31'h0, irq_o[m]},
              {31'h0, |(m_cap[m] & m_mask[m])});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nios_system_button_pio.md
# nios_system_button_pio

Parametrised Avalon-MM input PIO for the push-button and switch banks on the Nios II system bus. It replaces the fixed 4-bit, read-only, undebounced button port. Each input is synchronised and debounced, and selectable edges are captured into a sticky register. A maskable level interrupt is raised to the CPU, so game code no longer polls raw, bouncing keys.

## Interface
Parameters:
- WIDTH, 4: number of input bits, 1..32.
- DEBOUNCE_CYCLES, 50000: consecutive clk cycles a new input level must persist before it is accepted; minimum 1. The default is 1 ms at 50 MHz.
- EDGE_MODE, 0: 0 captures rising edges, 1 captures falling edges, 2 captures both, applied to the debounced value.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  synchronous active-low reset, sampled on clk rising edge.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon slave select; qualifies writes only.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits [WIDTH-1:0] used.
- in_port  in  WIDTH  asynchronous raw inputs from pins.
- readdata  out  32  registered read data, zero-extended above WIDTH.
- irq  out  1  level interrupt, active-high.

## Operation
- Synchroniser: two flops per bit (sync1, sync2), reset to 0.
- Debounce, per bit i:
  - The block holds a stable level deb[i] and a counter cnt[i] of width clog2(DEBOUNCE_CYCLES+1).
  - If sync2[i] == deb[i], cnt[i] is set to 0.
  - Otherwise, if cnt[i] == DEBOUNCE_CYCLES-1, then deb[i] <= sync2[i] and cnt[i] <= 0.
  - Otherwise cnt[i] increments by 1.
  - Any return to the stable level before expiry restarts the count, so glitches shorter than DEBOUNCE_CYCLES never reach deb.
- Edge detect: deb_d is a one-cycle-delayed copy of deb. The edge event is:
  - EDGE_MODE 0: ev = deb & ~deb_d.
  - EDGE_MODE 1: ev = ~deb & deb_d.
  - EDGE_MODE 2: ev = deb ^ deb_d.
- edge_cap register, WIDTH bits, sticky:
  - A bit is set by ev.
  - A bit is cleared by writing 1 to it at address 3 (write-1-to-clear).
  - If set and clear coincide on the same bit in the same cycle, set wins.
- irq_mask register, WIDTH bits, read/write at address 2.
- irq = |(edge_cap & irq_mask). It is a function of registers only, so it is glitch-free.
- Register map, with every register zero-extended to 32 bits on read:
  - 0: deb, read-only; writes are ignored.
  - 1: reads 0; writes are ignored.
  - 2: irq_mask.
  - 3: edge_cap.
- A write occurs when chipselect == 1 and write_n == 0 on a clk edge.
- readdata is updated on every clk edge from the address mux, independent of chipselect.
- Reset values, applied when reset_n is low at a clk edge: sync1, sync2, deb, deb_d, cnt, edge_cap, irq_mask and readdata are all 0, and irq is 0.
- If a button is held through reset, deb rises after the debounce latency once reset is released. In EDGE_MODE 0 or 2 that rise is captured as an edge; this is required behaviour.
- Reset asserted mid-count discards the partial count.

## Timing
- Read latency is 1 cycle: address sampled at edge k appears on readdata after edge k.
- Write latency: a register written at edge k is returned by a read whose address is sampled at edge k+1. A read and write to the same register at the same edge return the old value.
- in_port to deb:
  - in_port is sampled into sync1 at edge t and is in sync2 after edge t+1.
  - It must then be held stable so that deb updates at edge t+1+DEBOUNCE_CYCLES.
  - Total latency is DEBOUNCE_CYCLES+2 edges.
- deb change to edge_cap set: 1 edge later, via deb_d compare. irq asserts in the same cycle edge_cap is set, if the bit is masked in.
- Clearing edge_cap deasserts irq after the write edge, unless a new event sets the bit at that edge.

## Test plan
Parameters: WIDTH=4, DEBOUNCE_CYCLES=8, EDGE_MODE=0 unless noted.
1. Reset: hold reset_n=0 for 3 cycles with in_port=4'hF, then release. readdata=0 and irq=0 during reset. deb becomes 4'hF exactly 10 edges after release, and edge_cap then reads 4'hF.
2. Debounce reject: toggle in_port[0] high for 7 cycles, low for 1, high for 7. Address 0 reads 0 throughout. Holding the bit high for 8 more cycles then makes address 0 read 4'h1.
3. Edge capture and irq:
   - Write irq_mask=4'h2 and produce a clean rise on bit 1: edge_cap=4'h2 and irq=1.
   - Produce a rise on bit 2: edge_cap=4'h6 and irq stays 1.
   - Write 4'h2 to address 3: edge_cap=4'h4 and irq=0.
4. Set/clear collision: time a write of 4'h1 to address 3 to the same edge as a bit-0 event. edge_cap bit 0 remains 1.
5. Register map:
   - Write 32'hFFFF_FFFF to addresses 0, 1 and 2.
   - Address 0 is unchanged, address 1 reads 0, and address 2 reads 32'h0000_000F.
   - A write with chipselect=0 has no effect.
6. Modes: with EDGE_MODE=1, a fall on bit 3 gives edge_cap=4'h8 and a rise sets nothing. With EDGE_MODE=2, a rise then a fall on bit 0, with a clear in between, each set edge_cap bit 0.
